// File: rtl/backward_registered_skid_pkg.sv
// Shared pipeline definitions: skid stage state encodings and a width helper
// used by the beat counters along the pipeline.
package backward_registered_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    // Bits needed to count 0..value-1; matches $clog2 for value >= 2.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/frame_beat_counter.sv
// Counts accepted beats within a frame of DEPTH beats, flags the final beat
// and pulses frameDone_o on the cycle after that final beat is accepted.
module frame_beat_counter
    import backward_registered_skid_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int CNT_W = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             s_rst,
    input  logic             dstValid_i,
    input  logic             dstTake_i,
    output logic [CNT_W-1:0] beatCnt_o,
    output logic             last_o,
    output logic             frameDone_o
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DEPTH - 1);

    logic [CNT_W-1:0] beatCntQ, beatCntD;
    logic             frameDoneQ, frameDoneD;

    always_comb begin
        beatCntD   = beatCntQ;
        frameDoneD = 1'b0;
        if (dstTake_i) begin
            if (beatCntQ == LAST_BEAT) begin
                beatCntD   = '0;
                frameDoneD = 1'b1;
            end else begin
                beatCntD = beatCntQ + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            beatCntQ   <= '0;
            frameDoneQ <= 1'b0;
        end else begin
            beatCntQ   <= beatCntD;
            frameDoneQ <= frameDoneD;
        end
    end

    assign beatCnt_o   = beatCntQ;
    assign last_o      = dstValid_i & (beatCntQ == LAST_BEAT);
    assign frameDone_o = frameDoneQ;

endmodule

// File: rtl/backward_registered_skid.sv
// Valid/ready stage that registers the ready path with a one-entry skid
// register, plus frame beat counting for the downstream consumer.
module backward_registered_skid
    import backward_registered_skid_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int CNT_W = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             s_rst,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data_in,
    output logic             src_ready,
    output logic             dst_valid,
    output logic [WIDTH-1:0] dst_data_out,
    output logic             dst_last,
    input  logic             dst_ready,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             frame_done
);

    skid_state_t      stateQ, stateD;
    logic [WIDTH-1:0] outQ, outD;
    logic [WIDTH-1:0] skidQ, skidD;
    logic             srcReadyQ, srcReadyD;
    logic             dstValidQ, dstValidD;
    logic             srcTake;
    logic             dstTake;

    assign srcTake = src_valid & srcReadyQ;
    assign dstTake = dstValidQ & dst_ready;

    always_comb begin
        stateD = stateQ;
        outD   = outQ;
        skidD  = skidQ;
        case (stateQ)
            ST_EMPTY: begin
                if (srcTake) begin
                    outD   = src_data_in;
                    stateD = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (srcTake && dstTake) begin
                    outD = src_data_in;
                end else if (srcTake) begin
                    skidD  = src_data_in;
                    stateD = ST_FULL;
                end else if (dstTake) begin
                    stateD = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // Upstream is stalled here, so only the skid entry can move.
                if (dstTake) begin
                    outD   = skidQ;
                    stateD = ST_BUSY;
                end
            end
            default: begin
                stateD = ST_EMPTY;
            end
        endcase
        srcReadyD = (stateD != ST_FULL);
        dstValidD = (stateD != ST_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            stateQ    <= ST_EMPTY;
            outQ      <= '0;
            skidQ     <= '0;
            srcReadyQ <= 1'b0;
            dstValidQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            outQ      <= outD;
            skidQ     <= skidD;
            srcReadyQ <= srcReadyD;
            dstValidQ <= dstValidD;
        end
    end

    assign src_ready    = srcReadyQ;
    assign dst_valid    = dstValidQ;
    assign dst_data_out = outQ;

    frame_beat_counter #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_frame_beat_counter (
        .clk         (clk),
        .s_rst       (s_rst),
        .dstValid_i  (dstValidQ),
        .dstTake_i   (dstTake),
        .beatCnt_o   (beat_cnt),
        .last_o      (dst_last),
        .frameDone_o (frame_done)
    );

endmodule

// File: tb/tb_backward_registered_skid.sv
// Scoreboard bench for backward_registered_skid with 4-beat frames: accepted
// inputs are queued and a negedge monitor checks every output beat.
module tb_backward_registered_skid;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             s_rst;
    logic             src_valid;
    logic [WIDTH-1:0] src_data_in;
    logic             src_ready;
    logic             dst_valid;
    logic [WIDTH-1:0] dst_data_out;
    logic             dst_last;
    logic             dst_ready;
    logic [CNT_W-1:0] beat_cnt;
    logic             frame_done;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cycle;
    } sb_entry_t;

    sb_entry_t        sbQ[$];
    int               checks = 0;
    int               failures = 0;
    bit               monEn = 1'b0;
    bit               streamPhase = 1'b0;
    bit               framePhase = 1'b0;
    int               cycleNum = 0;
    int               tbBeat = 0;
    bit               expectFd = 1'b0;
    bit               prevStall = 1'b0;
    logic [WIDTH-1:0] prevData = '0;
    int               frameIdx = 0;
    logic [8:0]       lastMask = '0;
    int               fdCount = 0;

    backward_registered_skid #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .s_rst        (s_rst),
        .src_valid    (src_valid),
        .src_data_in  (src_data_in),
        .src_ready    (src_ready),
        .dst_valid    (dst_valid),
        .dst_data_out (dst_data_out),
        .dst_last     (dst_last),
        .dst_ready    (dst_ready),
        .beat_cnt     (beat_cnt),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Presents one beat and holds it until the DUT accepts it, bounded.
    task automatic applyStimulus(input logic [WIDTH-1:0] d);
        int waitCycles;
        waitCycles  = 0;
        src_valid   = 1'b1;
        src_data_in = d;
        @(negedge clk);
        while (!src_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!src_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout actual=stalled required=accept data=0x%0h", d);
        end
        @(posedge clk);
        #1;
        src_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        sb_entry_t e;
        bit        fdNext;
        if (monEn) begin
            cycleNum++;
            checkOutput("frame_done", 32'(frame_done), 32'(expectFd));
            if (framePhase && frame_done) fdCount++;
            fdNext = 1'b0;
            if (s_rst) begin
                sbQ.delete();
                tbBeat    = 0;
                prevStall = 1'b0;
            end else begin
                if (prevStall) begin
                    checkOutput("stall_valid", 32'(dst_valid), 32'd1);
                    checkOutput("stall_data", 32'(dst_data_out), 32'(prevData));
                end
                if (src_valid && src_ready) sbQ.push_back('{src_data_in, cycleNum});
                if (dst_valid && dst_ready) begin
                    if (sbQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL extra_beat actual=0x%0h required=no_output", dst_data_out);
                    end else begin
                        e = sbQ.pop_front();
                        checkOutput("data", 32'(dst_data_out), 32'(e.data));
                        if (streamPhase) checkOutput("latency", 32'(cycleNum - e.cycle), 32'd1);
                    end
                    checkOutput("beat_cnt", 32'(beat_cnt), 32'(tbBeat));
                    checkOutput("dst_last", 32'(dst_last), 32'(tbBeat == DEPTH - 1));
                    if (framePhase) begin
                        if (dst_last && frameIdx < 9) lastMask[frameIdx] = 1'b1;
                        frameIdx++;
                    end
                    if (tbBeat == DEPTH - 1) begin
                        tbBeat = 0;
                        fdNext = 1'b1;
                    end else begin
                        tbBeat++;
                    end
                end
                if (streamPhase) checkOutput("stream_src_ready", 32'(src_ready), 32'd1);
                prevStall = dst_valid && !dst_ready;
                prevData  = dst_data_out;
            end
            expectFd = fdNext;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        s_rst       = 1'b1;
        src_valid   = 1'b1;
        src_data_in = 8'h55;
        dst_ready   = 1'b1;
        @(posedge clk);
        #1;
        monEn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rst_dst_valid", 32'(dst_valid), 32'd0);
            checkOutput("rst_src_ready", 32'(src_ready), 32'd0);
            checkOutput("rst_beat_cnt", 32'(beat_cnt), 32'd0);
            @(posedge clk);
            #1;
        end
        s_rst     = 1'b0;
        src_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("release_src_ready", 32'(src_ready), 32'd1);
        checkOutput("release_dst_valid", 32'(dst_valid), 32'd0);

        $display("[TB] streaming");
        streamPhase = 1'b1;
        for (int i = 1; i <= 16; i++) applyStimulus(8'(i));
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        streamPhase = 1'b0;

        $display("[TB] backpressure");
        dst_ready = 1'b0;
        applyStimulus(8'hA1);
        applyStimulus(8'hA2);
        checkOutput("bp_src_ready", 32'(src_ready), 32'd0);
        checkOutput("bp_dst_valid", 32'(dst_valid), 32'd1);
        checkOutput("bp_head", 32'(dst_data_out), 32'hA1);
        src_valid   = 1'b1;
        src_data_in = 8'hA3;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("bp_stalled_ready", 32'(src_ready), 32'd0);
        checkOutput("bp_stalled_head", 32'(dst_data_out), 32'hA1);
        dst_ready = 1'b1;
        applyStimulus(8'hA3);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("bp_drained", 32'(sbQ.size()), 32'd0);

        $display("[TB] random");
        for (int i = 0; i < 2000; i++) begin
            src_valid   = 1'($urandom_range(0, 1));
            src_data_in = 8'($urandom);
            dst_ready   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        src_valid = 1'b0;
        dst_ready = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        checkOutput("rand_drained", 32'(sbQ.size()), 32'd0);

        $display("[TB] frame");
        s_rst = 1'b1;
        @(posedge clk);
        #1;
        s_rst = 1'b0;
        @(posedge clk);
        #1;
        framePhase = 1'b1;
        frameIdx   = 0;
        lastMask   = '0;
        fdCount    = 0;
        for (int i = 0; i < 9; i++) applyStimulus(8'h31 + 8'(i));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        framePhase = 1'b0;
        checkOutput("frame_last_mask", 32'(lastMask), 32'h088);
        checkOutput("frame_done_count", 32'(fdCount), 32'd2);
        checkOutput("frame_beat_cnt", 32'(beat_cnt), 32'd1);

        $display("[TB] mid-reset");
        dst_ready = 1'b0;
        applyStimulus(8'hB1);
        applyStimulus(8'hB2);
        checkOutput("mr_full_ready", 32'(src_ready), 32'd0);
        s_rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mr_dst_valid", 32'(dst_valid), 32'd0);
        checkOutput("mr_beat_cnt", 32'(beat_cnt), 32'd0);
        checkOutput("mr_src_ready", 32'(src_ready), 32'd0);
        s_rst     = 1'b0;
        dst_ready = 1'b1;
        applyStimulus(8'hC1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("mr_drained", 32'(sbQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
